// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: oversampled SCLK/SS_n/MOSI, any CPOL/CPHA, {opcode, payload} frames in,
// read-data returned on MISO. Define SPI_SLV_PARITY_EN to append an odd-parity bit to each frame.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              rx_err
);

`ifdef SPI_SLV_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = DATA_W + 2 + PAR_W;
  localparam int CNT_W   = $clog2(DATA_W + 4);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_TX_WAIT, S_TX, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_q, ss_q;

  // NOTE: synchroniser flops reset to the idle bus levels, not zero, so leaving reset
  // never fabricates an SCLK edge or an SS_n falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= CPOL;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_q == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ss_q && !ss_s;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [FRAME_W-1:0]  rx_shift, rx_shift_n;
  logic [DATA_W-1:0]   tx_shift, tx_shift_n;
  logic [DATA_W+1:0]   rx_data_n, frame;
  logic                miso_n, rx_valid_n, rx_err_n;
  logic                rd_addr_seen, rd_seen_n;
  logic                tx_armed, armed_n;
  logic                par_ok;

  assign frame = rx_shift[FRAME_W-1 -: DATA_W+2];
`ifdef SPI_SLV_PARITY_EN
  assign par_ok = ^rx_shift;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable gets its hold/default value first so no path infers a latch.
    state_n    = state;
    cnt_n      = cnt;
    rx_shift_n = rx_shift;
    tx_shift_n = tx_shift;
    miso_n     = MISO;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
    rd_seen_n  = rd_addr_seen;
    armed_n    = tx_armed;

    if (ss_s) begin
      state_n = S_IDLE;
      miso_n  = 1'b0;
      cnt_n   = '0;
      armed_n = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ss_fall) begin
            state_n    = S_RX;
            cnt_n      = '0;
            rx_shift_n = '0;
          end
        end
        S_RX: begin
          if (cnt == FRAME_CNT) begin
            if (par_ok) begin
              rx_data_n  = frame;
              rx_valid_n = 1'b1;
              state_n    = S_DONE;
              if (frame[DATA_W+1:DATA_W] == 2'b10) begin
                rd_seen_n = 1'b1;
              end else if (frame[DATA_W+1:DATA_W] == 2'b11 && rd_addr_seen) begin
                rd_seen_n = 1'b0;
                state_n   = S_TX_WAIT;
              end
            end else begin
              rx_err_n = 1'b1;
              state_n  = S_DONE;
            end
          end else if (sample_edge) begin
            rx_shift_n = {rx_shift[FRAME_W-2:0], mosi_s};
            cnt_n      = cnt + 1'b1;
          end
        end
        S_TX_WAIT: begin
          miso_n = 1'b0;
          if (tx_valid) begin
            state_n = S_TX;
            armed_n = 1'b0;
            if (!CPHA) begin
              miso_n     = tx_data[DATA_W-1];
              tx_shift_n = tx_data << 1;
              cnt_n      = CNT_W'(1);
            end else begin
              tx_shift_n = tx_data;
              cnt_n      = '0;
            end
          end
        end
        S_TX: begin
          if (cnt == DATA_CNT) begin
            state_n = S_DONE;
          end else begin
            // With CPHA=0 the trailing edge that closes the last RX bit must not shift;
            // only trailing edges after a master sample (leading) edge advance MISO.
            if (lead_edge) armed_n = 1'b1;
            if (shift_edge && (CPHA || tx_armed)) begin
              miso_n     = tx_shift[DATA_W-1];
              tx_shift_n = tx_shift << 1;
              cnt_n      = cnt + 1'b1;
            end
          end
        end
        S_DONE:  ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_err       <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_armed     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rx_shift     <= rx_shift_n;
      tx_shift     <= tx_shift_n;
      MISO         <= miso_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_err       <= rx_err_n;
      rd_addr_seen <= rd_seen_n;
      tx_armed     <= armed_n;
    end
  end

endmodule
